// File: rtl/subbytes_iter_if.sv
// Handshake bundle for subbytes_iter: input block stream, output result
// stream and the busy status flag.
interface subbytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/subbytes_iter.sv
// subbytes_iter: forward AES SubBytes over a 128-bit state.
// Default build substitutes one 32-bit word per cycle (4 cycles of RUN).
// Define SUBBYTES_FAST_EN to substitute all 16 bytes in a single RUN cycle.
// Byte 0 is bits [127:120], byte 15 is bits [7:0].

// FIPS-197 forward S-box, one byte.
module sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at the top of the table for x = 0; {~x, 3'b0} is 8*(255-x).
  assign y = SBOX_TAB[{~x, 3'b000} +: 8];
endmodule

module subbytes_iter (
  input  logic            clk,
  input  logic            rst,
  subbytes_iter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_next;
  logic [127:0] work_q;
  logic [127:0] work_next;
  logic         last_step;
  logic         accept;

  assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef SUBBYTES_FAST_EN
  // Whole-state substitution in one pass.
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    sbox u_sbox (.x(work_q[8*g +: 8]), .y(work_next[8*g +: 8]));
  end

  assign last_step = 1'b1;
`else
  logic [1:0]  cnt_q;
  logic [31:0] word_in;
  logic [31:0] word_sub;

  // Select the word addressed by the counter, word 0 being the top 32 bits.
  always_comb begin
    word_in = '0;
    case (cnt_q)
      2'd0: word_in = work_q[127:96];
      2'd1: word_in = work_q[95:64];
      2'd2: word_in = work_q[63:32];
      2'd3: word_in = work_q[31:0];
      default: word_in = '0;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (.x(word_in[8*g +: 8]), .y(word_sub[8*g +: 8]));
  end

  // Write the substituted word back in place; other words pass through.
  always_comb begin
    work_next = work_q;
    case (cnt_q)
      2'd0: work_next[127:96] = word_sub;
      2'd1: work_next[95:64]  = word_sub;
      2'd2: work_next[63:32]  = word_sub;
      2'd3: work_next[31:0]   = word_sub;
      default: work_next = work_q;
    endcase
  end

  assign last_step = (cnt_q == 2'd3);

  // Word counter: cleared on accept, advances (and wraps) every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end
`endif

  // Working register: captures the input block, then accumulates substitutions.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
    end else if (accept) begin
      work_q <= bus.in_data;
    end else if (state_q == RUN) begin
      work_q <= work_next;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = work_q;
endmodule

// File: tb/tb_subbytes_iter.sv
// Self-checking bench for subbytes_iter. The reference S-box is derived
// from GF(2^8) inversion plus the AES affine map, not from a lookup table.
module tb_subbytes_iter;
`ifdef SUBBYTES_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subbytes_iter_if bus();

  subbytes_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbox_ref [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_ref();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, confirm latency and result, then take the output.
  task automatic send_and_check(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int lat;
    check("pre in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = rand128();
    check("busy after accept", bus.busy, 1'b1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat, LAT);
    check(tag, bus.out_data, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("post in_ready", bus.in_ready, 1'b1);
    check("post out_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] exp_q [$];
    int sent, recvd, cycles, stray, lat;

    build_ref();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst busy", bus.busy, 1'b0);
    check("rst out_data", bus.out_data, '0);
    rst = 1'b0;
    step();

    // Known vectors
    send_and_check("fips c1", 128'h00102030405060708090a0b0c0d0e0f0,
                   128'h63cab7040953d051cd60e0e7ba70e18c);
    send_and_check("all zero", '0, {16{8'h63}});
    send_and_check("all ff", '1, {16{8'h16}});
    send_and_check("bytes 01 53", {8'h01, 8'h53, 112'h0}, {8'h7c, 8'hed, {14{8'h63}}});
    d = rand128();
    send_and_check("random", d, ref_sub(d));

    // Back-pressure in DONE
    d = rand128();
    e = ref_sub(d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("bp latency", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = rand128();
      step();
      check("bp out_valid", bus.out_valid, 1'b1);
      check("bp out_data", bus.out_data, e);
      check("bp in_ready", bus.in_ready, 1'b0);
    end
    // Output handshake with in_valid high: nothing may be captured on this edge
    bus.in_valid  = 1'b1;
    bus.in_data   = rand128();
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp release out_valid", bus.out_valid, 1'b0);
    check("bp release in_ready", bus.in_ready, 1'b1);
    check("bp release busy", bus.busy, 1'b0);
    check("bp release data kept", bus.out_data, e);

    // Reset abort during the second RUN cycle, overriding handshakes
    bus.in_valid = 1'b1;
    bus.in_data  = rand128();
    step();
    bus.in_valid = 1'b0;
    step();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("abort in_ready", bus.in_ready, 1'b1);
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort out_data", bus.out_data, '0);
    check("abort busy", bus.busy, 1'b0);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) stray++;
    end
    check("abort stray", stray, 0);
    d = rand128();
    send_and_check("after abort", d, ref_sub(d));

    // Random stream with random valid/ready
    sent   = 0;
    recvd  = 0;
    cycles = 0;
    d      = rand128();
    while ((sent < 100 || recvd < 100) && cycles < 20000) begin
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.in_data   = bus.in_valid ? d : rand128();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream extra", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("stream data", bus.out_data, e);
          recvd++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_sub(d));
        sent++;
        d = rand128();
      end
      step();
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream sent", sent, 100);
    check("stream recvd", recvd, 100);
    check("stream leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
